// File: rtl/midori64_pkg.sv
// -----------------------------------------------------------------------------
// midori64_pkg
// Shared constants, state encoding and helper functions for the Midori64
// decryption-side key scheduler.
//   NR          : number of Midori64 round keys (15)
//   ALPHA       : round constants alpha0..alpha14; bit n of a constant is
//                 XORed into key bit 4n, so bit 15 lands in the LSB of
//                 nibble 0 (key bit 60) and bit 0 in the LSB of nibble 15.
//   state_t     : FSM encoding (IDLE / RUN)
//   round_const : range-safe ALPHA lookup (returns 0 outside 0..NR-1)
//   nib_lsb_xor : XOR a 16-bit constant into the LSB of every nibble
//   mix_col64   : Midori involutive MixColumn over the 4x4 nibble state,
//                 nibbles stored column-major, nibble 0 = bits 63:60
// -----------------------------------------------------------------------------
package midori64_pkg;

    localparam int NR = 15;

    localparam logic [15:0] ALPHA [0:NR-1] = '{
        16'h15B3, 16'h78C0, 16'hA435, 16'h6213, 16'h104F,
        16'hD170, 16'h0266, 16'h0BCC, 16'h9481, 16'h40B8,
        16'h7197, 16'h228E, 16'h5130, 16'hF8CA, 16'hDF90
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } state_t;

    // Decoded lookup so that an out-of-range index (e.g. the wrapped
    // idx-1 when idx is already 0) never reads past the table.
    function automatic logic [15:0] round_const(input logic [3:0] i);
        logic [15:0] r;
        r = '0;
        for (int n = 0; n < NR; n++) begin
            if (i == 4'(n)) begin
                r = ALPHA[n];
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] nib_lsb_xor(input logic [63:0] key64,
                                                input logic [15:0] c16);
        logic [63:0] r;
        r = key64;
        for (int n = 0; n < 16; n++) begin
            r[4*n] = key64[4*n] ^ c16[n];
        end
        return r;
    endfunction

    // Each output nibble of a column is the XOR of the other three
    // nibbles of that column.
    function automatic logic [63:0] mix_col64(input logic [63:0] x64);
        logic [63:0] r;
        logic [3:0]  acc;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 4'h0;
                for (int k = 0; k < 4; k++) begin
                    if (k != j) begin
                        acc = acc ^ x64[63-4*(4*c+k) -: 4];
                    end
                end
                r[63-4*(4*c+j) -: 4] = acc;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/midori64_mc.sv
// -----------------------------------------------------------------------------
// midori64_mc
// Combinational Midori64 MixColumn (involutive), used to turn plain round
// keys into equivalent-inverse-cipher round keys.
//   x : 64-bit input state  (nibble 0 = bits 63:60, column-major)
//   y : 64-bit output state
// -----------------------------------------------------------------------------
module midori64_mc
    import midori64_pkg::*;
(
    input  logic [63:0] x,
    output logic [63:0] y
);

    assign y = mix_col64(x);

endmodule

// File: rtl/midori64_dec_key_sched.sv
// -----------------------------------------------------------------------------
// midori64_dec_key_sched
// Decryption-side Midori64 key scheduler. On an accepted start the two key
// halves are latched and round keys RK[NUM_RK-1] down to RK[0] are streamed
// over a valid/ready handshake, one per cycle when rk_ready stays high.
// RK[i] = (i odd ? k1 : k0) with ALPHA[i] XORed into every nibble LSB.
// The whitening key k0^k1 is registered on start and held.
//
// Optional build macro MIDORI64_DEC_EQKEY_EN: round keys are passed through
// MixColumn before the output register (equivalent inverse cipher keys),
// with identical timing. wk is not affected.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, k0, k1       run request and master key halves (sampled in IDLE)
//   busy                high while a run is in progress
//   wk                  whitening key k0^k1
//   rk, rk_idx          current round key and its index
//   rk_valid, rk_ready  output handshake
//   rk_last             rk_valid with rk_idx==0
//   done                one-cycle pulse after the final handshake
// -----------------------------------------------------------------------------
module midori64_dec_key_sched
    import midori64_pkg::*;
#(
    parameter int unsigned NUM_RK = NR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] k0,
    input  logic [63:0] k1,
    output logic        busy,
    output logic [63:0] wk,
    output logic [63:0] rk,
    output logic [3:0]  rk_idx,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic        rk_last,
    output logic        done
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_RK - 1);

    state_t      state_q, state_d;
    logic [63:0] k0_q, k0_d;
    logic [63:0] k1_q, k1_d;
    logic [63:0] wk_q, wk_d;
    logic [63:0] rk_q, rk_d;
    logic [3:0]  idx_q, idx_d;
    logic        rk_valid_q, rk_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Round key for the index that will be loaded next. In IDLE it comes
    // from the live key inputs so the first key is ready one cycle after
    // start; in RUN it comes from the latched halves.
    logic [3:0]  f_idx;
    logic [63:0] f_key;
    logic [63:0] rk_f;
    logic [63:0] rk_next;
    logic        in_idle;

    assign in_idle = (state_q == IDLE);
    assign f_idx   = in_idle ? LAST_IDX : (idx_q - 4'd1);
    assign f_key   = f_idx[0] ? (in_idle ? k1 : k1_q) : (in_idle ? k0 : k0_q);
    assign rk_f    = nib_lsb_xor(f_key, round_const(f_idx));

`ifdef MIDORI64_DEC_EQKEY_EN
    midori64_mc u_mc (
        .x (rk_f),
        .y (rk_next)
    );
`else
    assign rk_next = rk_f;
`endif

    always_comb begin
        state_d    = state_q;
        k0_d       = k0_q;
        k1_d       = k1_q;
        wk_d       = wk_q;
        rk_d       = rk_q;
        idx_d      = idx_q;
        rk_valid_d = rk_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    k0_d       = k0;
                    k1_d       = k1;
                    wk_d       = k0 ^ k1;
                    idx_d      = LAST_IDX;
                    rk_d       = rk_next;
                    rk_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                // start is deliberately not looked at here.
                if (rk_valid_q && rk_ready) begin
                    if (idx_q != 4'd0) begin
                        idx_d = idx_q - 4'd1;
                        rk_d  = rk_next;
                    end else begin
                        rk_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k0_q       <= '0;
            k1_q       <= '0;
            wk_q       <= '0;
            rk_q       <= '0;
            idx_q      <= '0;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k0_q       <= k0_d;
            k1_q       <= k1_d;
            wk_q       <= wk_d;
            rk_q       <= rk_d;
            idx_q      <= idx_d;
            rk_valid_q <= rk_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign wk       = wk_q;
    assign rk       = rk_q;
    assign rk_idx   = idx_q;
    assign rk_valid = rk_valid_q;
    assign rk_last  = rk_valid_q && (idx_q == 4'd0);
    assign done     = done_q;

endmodule

// File: tb/tb_midori64_dec_key_sched.sv
// -----------------------------------------------------------------------------
// tb_midori64_dec_key_sched
// Directed bench for midori64_dec_key_sched (default NUM_RK = 15).
// Round-key expectations come from a hand-expanded table: for a zero key,
// RK[i] has nibble n equal to bit (15-n) of alpha_i. When the build defines
// MIDORI64_DEC_EQKEY_EN the bench applies its own MixColumn to that value.
// -----------------------------------------------------------------------------
module tb_midori64_dec_key_sched;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] k0;
    logic [63:0] k1;
    logic        busy;
    logic [63:0] wk;
    logic [63:0] rk;
    logic [3:0]  rk_idx;
    logic        rk_valid;
    logic        rk_ready;
    logic        rk_last;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    midori64_dec_key_sched dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .k0       (k0),
        .k1       (k1),
        .busy     (busy),
        .wk       (wk),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_last  (rk_last),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic [63:0] base;   // RK[idx] for k0 = k1 = 0
    } rk_vec_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        bit          rnd;      // random rk_ready
        int          inj;      // rk_idx at which a stray start is pulsed (-1 none)
        int          rst_at;   // rk_idx at which rst is pulsed (-1 none)
    } run_t;

    rk_vec_t rk_tbl [15];
    run_t    runs   [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] tb_mc(input logic [63:0] x);
        logic [63:0] r;
        logic [3:0]  s [16];
        for (int n = 0; n < 16; n++) s[n] = x[63-4*n -: 4];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[63-4*(4*c+0) -: 4] = s[4*c+1] ^ s[4*c+2] ^ s[4*c+3];
            r[63-4*(4*c+1) -: 4] = s[4*c+0] ^ s[4*c+2] ^ s[4*c+3];
            r[63-4*(4*c+2) -: 4] = s[4*c+0] ^ s[4*c+1] ^ s[4*c+3];
            r[63-4*(4*c+3) -: 4] = s[4*c+0] ^ s[4*c+1] ^ s[4*c+2];
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_rk(input logic [63:0] a, input logic [63:0] b, input int i);
        logic [63:0] r;
        r = rk_tbl[i].base ^ ((i % 2 == 1) ? b : a);
`ifdef MIDORI64_DEC_EQKEY_EN
        r = tb_mc(r);
`endif
        return r;
    endfunction

    // Called on a falling edge; leaves the bench on a falling edge.
    task automatic run_keys(input run_t r, input int run_no);
        int          exp_i;
        int          cyc;
        bit          held;
        logic [63:0] prv_rk;
        logic [3:0]  prv_idx;
        k0       = r.a;
        k1       = r.b;
        start    = 1'b1;
        rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("first_valid_latency", 64'(rk_valid), 64'd1);
        chk("busy_after_start", 64'(busy), 64'd1);
        exp_i = 14;
        held  = 1'b0;
        cyc   = 0;
        prv_rk  = '0;
        prv_idx = '0;
        while (exp_i >= 0 && cyc < 300) begin
            if (r.rst_at == exp_i) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_midrun_outputs", {61'd0, busy, rk_valid, done}, 64'd0);
                chk("rst_midrun_rk", rk, 64'd0);
                chk("rst_midrun_wk", wk, 64'd0);
                chk("rst_midrun_idx_last", {59'd0, rk_idx, rk_last}, 64'd0);
                @(negedge clk);
                chk("rst_midrun_no_done", {62'd0, done, busy}, 64'd0);
                $display("run %0d: reset abandoned sequence at rk_idx %0d", run_no, r.rst_at);
                return;
            end
            if (held) begin
                chk("stall_rk_stable", rk, prv_rk);
                chk("stall_idx_stable", 64'(rk_idx), 64'(prv_idx));
            end
            chk("rk_valid", 64'(rk_valid), 64'd1);
            chk("rk_idx", 64'(rk_idx), 64'(rk_tbl[exp_i].idx));
            chk("rk_value", rk, exp_rk(r.a, r.b, exp_i));
            chk("rk_last", 64'(rk_last), 64'(exp_i == 0));
            chk("wk_held", wk, r.a ^ r.b);
            if (r.inj == exp_i) begin
                start = 1'b1;
                k0    = ~r.a;
                k1    = ~r.b;
            end else begin
                start = 1'b0;
            end
            rk_ready = r.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            held     = !rk_ready;
            prv_rk   = rk;
            prv_idx  = rk_idx;
            if (rk_ready) exp_i--;
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        rk_ready = 1'b0;
        if (exp_i >= 0) begin
            chk("sequence_timeout", 64'(exp_i), 64'hFFFF_FFFF_FFFF_FFFF);
        end
        chk("done_pulse", 64'(done), 64'd1);
        chk("valid_drop", {62'd0, rk_valid, busy}, 64'd0);
        chk("rk_idx_kept", 64'(rk_idx), 64'd0);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_after_done", 64'(busy), 64'd0);
        chk("wk_final", wk, r.a ^ r.b);
        $display("run %0d: k0=%h k1=%h rnd=%0d inj=%0d delivered 15 keys in %0d cycles",
                 run_no, r.a, r.b, r.rnd, r.inj, cyc);
    endtask

    initial begin
        rk_tbl[0]  = '{4'd0,  64'h0001_0101_1011_0011};
        rk_tbl[1]  = '{4'd1,  64'h0111_1000_1100_0000};
        rk_tbl[2]  = '{4'd2,  64'h1010_0100_0011_0101};
        rk_tbl[3]  = '{4'd3,  64'h0110_0010_0001_0011};
        rk_tbl[4]  = '{4'd4,  64'h0001_0000_0100_1111};
        rk_tbl[5]  = '{4'd5,  64'h1101_0001_0111_0000};
        rk_tbl[6]  = '{4'd6,  64'h0000_0010_0110_0110};
        rk_tbl[7]  = '{4'd7,  64'h0000_1011_1100_1100};
        rk_tbl[8]  = '{4'd8,  64'h1001_0100_1000_0001};
        rk_tbl[9]  = '{4'd9,  64'h0100_0000_1011_1000};
        rk_tbl[10] = '{4'd10, 64'h0111_0001_1001_0111};
        rk_tbl[11] = '{4'd11, 64'h0010_0010_1000_1110};
        rk_tbl[12] = '{4'd12, 64'h0101_0001_0011_0000};
        rk_tbl[13] = '{4'd13, 64'h1111_1000_1100_1010};
        rk_tbl[14] = '{4'd14, 64'h1101_1111_1001_0000};

        runs[0] = '{64'h0,                     64'h0,                     1'b0, -1, -1};
        runs[1] = '{64'h0,                     64'h1111_1111_1111_1111,   1'b0, -1, -1};
        runs[2] = '{64'h0123_4567_89AB_CDEF,   64'hFEDC_BA98_7654_3210,   1'b1, -1, -1};
        runs[3] = '{64'hA5A5_0F0F_3C3C_9696,   64'h1234_5678_9ABC_DEF0,   1'b0,  7, -1};
        runs[4] = '{64'h0123_4567_89AB_CDEF,   64'h0,                     1'b0, -1, -1};
        runs[5] = '{64'hDEAD_BEEF_CAFE_F00D,   64'h0BAD_F00D_1357_9BDF,   1'b0, -1,  9};
        runs[6] = '{64'hDEAD_BEEF_CAFE_F00D,   64'h0BAD_F00D_1357_9BDF,   1'b1, -1, -1};
        runs[7] = '{64'h5555_AAAA_5555_AAAA,   64'h3333_CCCC_3333_CCCC,   1'b0,  0, -1};

        rst      = 1'b1;
        start    = 1'b0;
        k0       = 64'h0123_4567_89AB_CDEF;
        k1       = 64'hFFFF_0000_FFFF_0000;
        rk_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {60'd0, busy, rk_valid, rk_last, done}, 64'd0);
        chk("reset_wk", wk, 64'd0);
        chk("reset_rk", rk, 64'd0);
        chk("reset_idx", 64'(rk_idx), 64'd0);
        $display("reset: outputs checked");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start", 64'(busy), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_keys(runs[i], i);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
